// File: rtl/mem_arbiter.sv
// Round-robin two-requester controller for a single-port synchronous memory.
// Sequences reads and writes and provides a zero-fill init sweep.
module mem_arbiter #(
    parameter int W     = 7,
    parameter int DEPTH = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_0,
    input  logic         req_1,
    input  logic         we_0,
    input  logic         we_1,
    input  logic [3:0]   addr_0,
    input  logic [3:0]   addr_1,
    input  logic [W:0]   wdata_0,
    input  logic [W:0]   wdata_1,
    output logic         gnt_0,
    output logic         gnt_1,
    output logic         rvalid_0,
    output logic         rvalid_1,
    output logic [W:0]   rdata_0,
    output logic [W:0]   rdata_1,
    input  logic         init_start,
    output logic         init_done,
    output logic         busy,
    output logic         mem_enable,
    output logic         mem_wrt_read,
    output logic [3:0]   mem_add,
    output logic [W:0]   mem_write,
    input  logic [W:0]   mem_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, INIT} state_t;

    localparam logic [3:0] LAST = 4'(DEPTH - 1);

    state_t state;
    logic   ptr;
    logic   owner;
    logic   op_we;
    logic   init_pending;
    logic   win;

    // Single requester wins outright; on a tie the pointer decides.
    always_comb begin
        win = (req_0 && req_1) ? ptr : req_1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            owner        <= 1'b0;
            op_we        <= 1'b0;
            init_pending <= 1'b0;
            gnt_0        <= 1'b0;
            gnt_1        <= 1'b0;
            rvalid_0     <= 1'b0;
            rvalid_1     <= 1'b0;
            rdata_0      <= '0;
            rdata_1      <= '0;
            init_done    <= 1'b0;
            busy         <= 1'b0;
            mem_enable   <= 1'b0;
            mem_wrt_read <= 1'b0;
            mem_add      <= '0;
            mem_write    <= '0;
        end else begin
            rvalid_0  <= 1'b0;
            rvalid_1  <= 1'b0;
            init_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (init_pending || init_start) begin
                        state        <= INIT;
                        init_pending <= 1'b0;
                        busy         <= 1'b1;
                        mem_enable   <= 1'b1;
                        mem_wrt_read <= 1'b1;
                        mem_add      <= '0;
                        mem_write    <= '0;
                    end else if (req_0 || req_1) begin
                        state        <= ISSUE;
                        busy         <= 1'b1;
                        owner        <= win;
                        ptr          <= ~win;
                        gnt_0        <= ~win;
                        gnt_1        <= win;
                        op_we        <= win ? we_1 : we_0;
                        mem_enable   <= 1'b1;
                        mem_wrt_read <= win ? we_1 : we_0;
                        mem_add      <= win ? addr_1 : addr_0;
                        mem_write    <= win ? wdata_1 : wdata_0;
                    end
                end
                ISSUE: begin
                    mem_enable <= 1'b0;
                    gnt_0      <= 1'b0;
                    gnt_1      <= 1'b0;
                    if (init_start) begin
                        init_pending <= 1'b1;
                    end
                    if (op_we) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (init_start) begin
                        init_pending <= 1'b1;
                    end
                    if (owner) begin
                        rdata_1  <= mem_out;
                        rvalid_1 <= 1'b1;
                    end else begin
                        rdata_0  <= mem_out;
                        rvalid_0 <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                INIT: begin
                    if (mem_add == LAST) begin
                        mem_enable   <= 1'b0;
                        mem_wrt_read <= 1'b0;
                        init_done    <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        mem_add <= mem_add + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural single-port memory.
// Driver pushes expected grants/read data/sweeps; a negedge monitor pops them.
module tb_mem_arbiter;

    localparam int DEPTH = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_0, req_1, we_0, we_1;
    logic [3:0] addr_0, addr_1;
    logic [7:0] wdata_0, wdata_1;
    logic       gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [7:0] rdata_0, rdata_1;
    logic       init_start, init_done, busy;
    logic       mem_enable, mem_wrt_read;
    logic [3:0] mem_add;
    logic [7:0] mem_write, mem_out;

    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         p;
        bit         w;
        logic [3:0] a;
        logic [7:0] d;
    } gexp_t;

    typedef struct {
        bit         p;
        logic [7:0] d;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    iq[$];
    int    sweep_idx = 0;

    mem_arbiter #(.W(7), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .req_1(req_1),
        .we_0(we_0), .we_1(we_1),
        .addr_0(addr_0), .addr_1(addr_1),
        .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1),
        .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1),
        .init_start(init_start), .init_done(init_done),
        .busy(busy),
        .mem_enable(mem_enable), .mem_wrt_read(mem_wrt_read),
        .mem_add(mem_add), .mem_write(mem_write),
        .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_wrt_read) mem[mem_add] <= mem_write;
            else mem_out <= mem[mem_add];
        end
    end

    task automatic chk(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0h want %0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    gexp_t ge;
    rexp_t re;
    always @(negedge clk) begin
        if (reset) begin
            sweep_idx = 0;
        end else begin
            if (gnt_0 || gnt_1) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 1'b0, {gnt_1, gnt_0}, 0);
                end else begin
                    ge = gq.pop_front();
                    chk("gnt", !(gnt_0 && gnt_1) && gnt_1 == ge.p
                        && mem_enable && mem_wrt_read == ge.w
                        && mem_add == ge.a && (!ge.w || mem_write == ge.d)
                        && iq.size() == 0,
                        {gnt_1, gnt_0, 3'b0, mem_wrt_read, mem_add, mem_write},
                        {1'b0, ge.p, 3'b0, ge.w, ge.a, ge.d});
                end
            end
            if (rvalid_0 || rvalid_1) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", 1'b0, {rvalid_1, rvalid_0}, 0);
                end else begin
                    re = rq.pop_front();
                    chk("rvalid", !(rvalid_0 && rvalid_1) && rvalid_1 == re.p
                        && (re.p ? rdata_1 : rdata_0) == re.d,
                        {rvalid_1, 3'b0, re.p ? rdata_1 : rdata_0},
                        {re.p, 3'b0, re.d});
                end
            end
            if (mem_enable && !gnt_0 && !gnt_1) begin
                chk("sweep", mem_add == 4'(sweep_idx) && mem_wrt_read
                    && mem_write == 0 && busy,
                    {mem_wrt_read, mem_add, mem_write}, {1'b1, 4'(sweep_idx), 8'h0});
                sweep_idx++;
            end
            if (init_done) begin
                if (iq.size() == 0) begin
                    chk("init_done_unexpected", 1'b0, 1, 0);
                end else begin
                    void'(iq.pop_front());
                    chk("sweep_len", sweep_idx == DEPTH, sweep_idx, DEPTH);
                end
                sweep_idx = 0;
            end
        end
    end

    task automatic set_req(input bit p, input bit r, input bit w,
                           input logic [3:0] a, input logic [7:0] d);
        if (p) begin
            req_1 = r; we_1 = w; addr_1 = a; wdata_1 = d;
        end else begin
            req_0 = r; we_0 = w; addr_0 = a; wdata_0 = d;
        end
    endtask

    task automatic wait_gnt(input bit p);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (p ? gnt_1 : gnt_0) seen = 1'b1;
        end
        if (!seen) chk("gnt_timeout", 1'b0, p, p);
    endtask

    // Returns #1 after the edge that raises the grant (inside the gnt cycle).
    task automatic issue(input bit p, input bit w, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] rd);
        gq.push_back('{p: p, w: w, a: a, d: d});
        if (!w) rq.push_back('{p: p, d: rd});
        set_req(p, 1'b1, w, a, d);
        wait_gnt(p);
        set_req(p, 1'b0, 1'b0, 4'h0, 8'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        gq.delete();
        rq.delete();
        iq.delete();
    endtask

    function automatic bit all_zero();
        return !gnt_0 && !gnt_1 && !rvalid_0 && !rvalid_1 && rdata_0 == 0
            && rdata_1 == 0 && !init_done && !busy && !mem_enable
            && !mem_wrt_read && mem_add == 0 && mem_write == 0;
    endfunction

    task automatic do_reset(input string name);
        reset = 1'b1;
        flush();
        @(posedge clk);
        #1;
        chk(name, all_zero(), {busy, mem_enable, mem_add, rdata_1, rdata_0}, 0);
        reset = 1'b0;
    endtask

    task automatic both_reads(input int n, input logic [3:0] a0, input logic [7:0] d0,
                              input logic [3:0] a1, input logic [7:0] d1);
        int g = 0;
        for (int i = 0; i < n; i++) begin
            gq.push_back('{p: i[0], w: 1'b0, a: i[0] ? a1 : a0, d: 8'h0});
            rq.push_back('{p: i[0], d: i[0] ? d1 : d0});
        end
        set_req(1'b0, 1'b1, 1'b0, a0, 8'h0);
        set_req(1'b1, 1'b1, 1'b0, a1, 8'h0);
        for (int i = 0; i < 10 * n && g < n; i++) begin
            @(posedge clk);
            #1;
            if (gnt_0 || gnt_1) g++;
        end
        chk("grant_count", g == n, g, n);
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h0);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        idle(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit ok;
        reset = 1'b1;
        init_start = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h0);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        idle(2);
        chk("reset_state", all_zero(), {busy, mem_enable, mem_add}, 0);
        reset = 1'b0;
        idle(1);

        // Write then read back through the other port
        issue(1'b0, 1'b1, 4'd3, 8'h5A, 8'h0);
        idle(1);
        chk("write_back_idle", !busy && !mem_enable, {busy, mem_enable}, 0);
        issue(1'b1, 1'b0, 4'd3, 8'h0, 8'h5A);
        idle(1);
        chk("rd_lat_n1", !rvalid_1, rvalid_1, 0);
        idle(1);
        chk("rd_lat_n2", rvalid_1 && rdata_1 == 8'h5A, {rvalid_1, rdata_1}, 9'h15A);
        idle(2);
        chk("rdata_hold", rdata_0 == 0 && rdata_1 == 8'h5A,
            {rdata_0, rdata_1}, 16'h005A);
        issue(1'b1, 1'b1, 4'd7, 8'h3C, 8'h0);
        idle(2);

        // Round robin after reset
        do_reset("reset_idle");
        both_reads(8, 4'd3, 8'h5A, 4'd7, 8'h3C);

        // Fill, sweep, read back zeros; address 11 lies beyond the sweep
        for (int a = 0; a < DEPTH; a++) begin
            issue(a[0], 1'b1, 4'(a), 8'hFF, 8'h0);
        end
        issue(1'b1, 1'b1, 4'd11, 8'hEE, 8'h0);
        idle(2);
        iq.push_back(1);
        init_start = 1'b1;
        idle(1);
        init_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (init_done) ok = 1'b1;
        end
        chk("init_done_seen", ok, ok, 1);
        idle(1);
        for (int a = 0; a < DEPTH; a++) begin
            issue(a[0], 1'b0, 4'(a), 8'h0, 8'h00);
        end
        issue(1'b0, 1'b0, 4'd11, 8'h0, 8'hEE);
        idle(3);

        // init_start during RDWAIT with a concurrent request
        issue(1'b1, 1'b1, 4'd5, 8'h77, 8'h0);
        issue(1'b0, 1'b0, 4'd5, 8'h0, 8'h77);
        idle(1);
        iq.push_back(1);
        init_start = 1'b1;
        gq.push_back('{p: 1'b0, w: 1'b1, a: 4'd6, d: 8'h66});
        set_req(1'b0, 1'b1, 1'b1, 4'd6, 8'h66);
        idle(1);
        init_start = 1'b0;
        chk("rdwait_rvalid", rvalid_0 && rdata_0 == 8'h77, {rvalid_0, rdata_0}, 9'h177);
        idle(1);
        chk("init_after_rd", mem_enable && mem_wrt_read && mem_add == 0 && busy
            && !gnt_0, {mem_enable, mem_wrt_read, mem_add, busy}, 7'b1100001);
        wait_gnt(1'b0);
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h0);
        idle(3);

        // Reset during RDWAIT, then during the sweep
        issue(1'b0, 1'b0, 4'd6, 8'h0, 8'h66);
        idle(1);
        do_reset("reset_rdwait");
        idle(3);
        iq.push_back(1);
        init_start = 1'b1;
        idle(1);
        init_start = 1'b0;
        idle(4);
        do_reset("reset_init");
        idle(16);
        chk("no_late_done", !busy && rvalid_0 == 0 && rdata_0 == 0,
            {busy, rvalid_0, rdata_0}, 0);

        // Pointer favours requester 0 again
        both_reads(2, 4'd6, 8'h66, 4'd11, 8'hEE);

        idle(4);
        chk("queues_empty", gq.size() == 0 && rq.size() == 0 && iq.size() == 0,
            {gq.size(), rq.size(), iq.size()}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester controller for the single-port synchronous memory (registered read data, 1-cycle read latency; enable/wrt_read/add/write interface).
- Arbitrates round-robin between requester 0 and requester 1, sequences each access, and returns read data with a valid pulse to the owning requester.
- Provides a zero-fill init sweep so software can clear every word without a global reset.
- Sits between client blocks and the memory instance; it is the only driver of the memory's control inputs.

Parameters:
- W, 7, data MSB index; data width is W+1.
- DEPTH, 11, number of words cleared by the init sweep, addresses 0..DEPTH-1; must be ≤ 16.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_0, req_1  input  1  access request per requester.
- we_0, we_1  input  1  1 = write, 0 = read.
- addr_0, addr_1  input  4  word address.
- wdata_0, wdata_1  input  W+1  write data.
- gnt_0, gnt_1  output  1  one-cycle grant pulse; the access is committed.
- rvalid_0, rvalid_1  output  1  one-cycle read-data-valid pulse.
- rdata_0, rdata_1  output  W+1  read data; holds the last value.
- init_start  input  1  pulse that requests the zero-fill sweep.
- init_done  output  1  one-cycle pulse when the sweep completes.
- busy  output  1  high in every state except IDLE.
- mem_enable  output  1  to memory enable.
- mem_wrt_read  output  1  to memory wrt_read.
- mem_add  output  4  to memory add.
- mem_write  output  W+1  to memory write.
- mem_out  input  W+1  from memory out.

Behaviour:
- Reset: all outputs are 0; state = IDLE; priority pointer = 0; init_pending = 0.
- Reset mid-operation aborts immediately. An in-flight read produces no rvalid. An aborted sweep produces no init_done.
- All outputs are registered. States: IDLE, ISSUE, RDWAIT, INIT.
- IDLE, init_pending or init_start high: go to INIT on the next edge. Set mem_enable=1, mem_wrt_read=1, mem_add=0, mem_write=0, clear init_pending. Init has priority over requests.
- IDLE, requests present, no init: choose the winner.
  - Only one req high: that requester wins.
  - Both high: the requester named by the pointer wins.
  - On the edge: load the winner's we/addr/wdata onto the mem_* outputs, set mem_enable=1 and gnt_winner=1, record owner, set pointer = other requester. Next state is ISSUE.
- ISSUE: lasts exactly 1 cycle with mem_enable high and gnt high; the memory samples at the closing edge.
  - On that edge, clear mem_enable and gnt.
  - Write: go to IDLE. Write throughput is 1 op per 2 cycles.
  - Read: go to RDWAIT.
- RDWAIT: mem_out is valid in this cycle. On the edge, set rdata_owner=mem_out and rvalid_owner=1 for 1 cycle, then go to IDLE. The non-owner's rdata is unchanged.
  - Read latency: the edge that raises gnt is edge N; rvalid is high after edge N+2.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt is seen.
  - Deassert req (or present the next request) at the edge that ends the gnt cycle.
  - req is sampled only in IDLE.
- INIT: mem_enable and mem_wrt_read stay high with mem_write=0.
  - mem_add increments by 1 per cycle from 0 to DEPTH-1.
  - On the edge after the cycle where mem_add=DEPTH-1: clear mem_enable, pulse init_done, go to IDLE.
  - The sweep takes DEPTH cycles of mem_enable. Requests wait and are not granted during INIT.
- init_start outside IDLE:
  - In ISSUE or RDWAIT: set init_pending; the sweep starts at the next IDLE.
  - In INIT: ignored, no restart.
- init_start in IDLE together with req: init wins; the request is granted after init_done.
- Addresses are used unchanged (no wrap or masking). Reads of addresses ≥ memory depth are undefined.

Test Plan:
- Reset, then req_0 write addr=3 wdata=0x5A: gnt_0 is 1 cycle. mem_enable=1, mem_wrt_read=1, mem_add=3, mem_write=0x5A in that same cycle. Back to IDLE the next cycle.
- After that, req_1 read addr=3: gnt_1 pulse. rvalid_1 is high 2 cycles after gnt_1 with rdata_1=0x5A. rvalid_0 stays 0 and rdata_0 stays 0.
- req_0 and req_1 held continuously, both reads, after reset: grants alternate 0,1,0,1. Each rvalid goes to the correct port. No starvation over 8 grants.
- Write 0xFF to addresses 0..10, pulse init_start: mem_add steps 0..10 over 11 cycles with mem_write=0, then init_done pulses once. Reads of addresses 0..10 return 0.
- init_start during a read's RDWAIT: the read still completes with its rvalid, then INIT starts from address 0 on the next cycle. A concurrent req_0 is granted only after init_done.
- Assert reset in RDWAIT and mid-INIT: all outputs are 0 next cycle, no rvalid, no init_done, busy=0, and the pointer favours requester 0.
